punc_control: RTL and testbench

//  Multicycle control FSM for the PUnC LC3 processor, the controller end of the datapath's control interface.

---
 rtl/punc_defs.sv | 79 +++++++
 rtl/punc_ctrl_decode.sv | 129 ++++++++++++
 rtl/punc_control.sv | 89 ++++++++
 tb/tb_punc_control.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/punc_defs.sv
// Shared encodings for the PUnC LC3 controller and datapath.
// Holds opcodes, controller states, every mux-select encoding and the control word.
// Both ends of the control interface import this package.
package punc_defs;

    localparam int OPC_W   = 4;
    localparam int STATE_W = 3;

    // LC3 opcodes (ir[15:12])
    localparam logic [OPC_W-1:0] OP_BR   = 4'b0000;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OPC_W-1:0] OP_LD   = 4'b0010;
    localparam logic [OPC_W-1:0] OP_ST   = 4'b0011;
    localparam logic [OPC_W-1:0] OP_JSR  = 4'b0100;
    localparam logic [OPC_W-1:0] OP_AND  = 4'b0101;
    localparam logic [OPC_W-1:0] OP_LDR  = 4'b0110;
    localparam logic [OPC_W-1:0] OP_STR  = 4'b0111;
    localparam logic [OPC_W-1:0] OP_RTI  = 4'b1000;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'b1001;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'b1010;
    localparam logic [OPC_W-1:0] OP_STI  = 4'b1011;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'b1100;
    localparam logic [OPC_W-1:0] OP_RES  = 4'b1101;
    localparam logic [OPC_W-1:0] OP_LEA  = 4'b1110;
    localparam logic [OPC_W-1:0] OP_TRAP = 4'b1111;

    // Controller states; codes 5..7 are illegal and recover to FETCH
    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd0;
    localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
    localparam logic [STATE_W-1:0] ST_EXEC2  = 3'd3;
    localparam logic [STATE_W-1:0] ST_HALT   = 3'd4;

    // PC source
    localparam logic       PC_SEL_ADDER = 1'b0;
    localparam logic       PC_SEL_REG   = 1'b1;
    // Sign-extender field select
    localparam logic [1:0] EXT_PC6      = 2'd0;
    localparam logic [1:0] EXT_PC9      = 2'd1;
    localparam logic [1:0] EXT_PC11     = 2'd2;
    localparam logic [1:0] EXT_IMM5     = 2'd3;
    // Adder/ALU operand 1
    localparam logic [1:0] OP1_BASE     = 2'd0;
    localparam logic [1:0] OP1_RDATA0   = 2'd1;
    localparam logic [1:0] OP1_PC       = 2'd2;
    // Adder/ALU operand 2
    localparam logic       OP2_RDATA1   = 1'b0;
    localparam logic       OP2_EXT      = 1'b1;
    // ALU function
    localparam logic [1:0] ALU_SUM      = 2'd0;
    localparam logic [1:0] ALU_AND      = 2'd1;
    localparam logic [1:0] ALU_NOT      = 2'd2;
    localparam logic [1:0] ALU_PASS     = 2'd3;
    // Memory address source
    localparam logic [1:0] MADDR_PC     = 2'd0;
    localparam logic [1:0] MADDR_ADDER  = 2'd1;
    localparam logic [1:0] MADDR_MDR    = 2'd2;

    // Full control word driven onto the datapath each cycle
    typedef struct packed {
        logic       ir_ld;
        logic       pc_inc;
        logic       pc_ld;
        logic       pc_sel;
        logic [1:0] ext_sel;
        logic [1:0] op1_sel;
        logic       op2_sel;
        logic [1:0] alu_sel;
        logic       rf_w_en;
        logic       rf_w_r7;
        logic       rf_r_r7;
        logic [1:0] mem_addr_sel;
        logic       mem_w_en;
        logic       mdr_ld;
        logic       nzp_ld;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/punc_ctrl_decode.sv
// Combinational decode of (state, opcode, IR bits, NZP) into the datapath control word.
// Latency: zero cycles, pure combinational.
// Backpressure: none; the datapath consumes every strobe on the next rising edge.
module punc_ctrl_decode
    import punc_defs::*;
(
    input  logic [STATE_W-1:0] i_state,
    input  logic [OPC_W-1:0]   i_opcode,
    input  logic               i_ir_11,
    input  logic               i_ir_5,
    input  logic [2:0]         i_ir_cond,
    input  logic [2:0]         i_nzp,
    output ctrl_t              o_ctrl
);

    logic w_br_taken;
    assign w_br_taken = |(i_ir_cond & i_nzp);

    // Control word per state and opcode; anything not named stays zero.
    // rf_r_r7 is never raised: RET reads R7 through its own base field.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_addr_sel = MADDR_PC;
                o_ctrl.ir_ld        = 1'b1;
            end
            ST_DECODE: begin
                o_ctrl.pc_inc = (i_opcode != OP_TRAP);
            end
            ST_EXEC: begin
                case (i_opcode)
                    OP_ADD, OP_AND: begin
                        o_ctrl.op1_sel = OP1_RDATA0;
                        o_ctrl.op2_sel = i_ir_5 ? OP2_EXT : OP2_RDATA1;
                        o_ctrl.ext_sel = EXT_IMM5;
                        o_ctrl.alu_sel = (i_opcode == OP_AND) ? ALU_AND : ALU_SUM;
                        o_ctrl.rf_w_en = 1'b1;
                        o_ctrl.nzp_ld  = 1'b1;
                    end
                    OP_NOT: begin
                        o_ctrl.op1_sel = OP1_RDATA0;
                        o_ctrl.alu_sel = ALU_NOT;
                        o_ctrl.rf_w_en = 1'b1;
                        o_ctrl.nzp_ld  = 1'b1;
                    end
                    OP_BR: begin
                        o_ctrl.op1_sel = OP1_PC;
                        o_ctrl.ext_sel = EXT_PC9;
                        o_ctrl.op2_sel = OP2_EXT;
                        o_ctrl.alu_sel = ALU_SUM;
                        o_ctrl.pc_sel  = PC_SEL_ADDER;
                        o_ctrl.pc_ld   = w_br_taken;
                    end
                    OP_JMP: begin
                        o_ctrl.op1_sel = OP1_BASE;
                        o_ctrl.pc_sel  = PC_SEL_REG;
                        o_ctrl.pc_ld   = 1'b1;
                    end
                    OP_JSR: begin
                        // R7 captures the already-incremented PC on the same edge the PC reloads
                        o_ctrl.op1_sel = OP1_PC;
                        o_ctrl.ext_sel = EXT_PC11;
                        o_ctrl.op2_sel = OP2_EXT;
                        o_ctrl.alu_sel = ALU_SUM;
                        o_ctrl.pc_sel  = i_ir_11 ? PC_SEL_ADDER : PC_SEL_REG;
                        o_ctrl.pc_ld   = 1'b1;
                        o_ctrl.rf_w_en = 1'b1;
                        o_ctrl.rf_w_r7 = 1'b1;
                    end
                    OP_LD, OP_LDR: begin
                        o_ctrl.op1_sel      = (i_opcode == OP_LDR) ? OP1_BASE : OP1_PC;
                        o_ctrl.ext_sel      = (i_opcode == OP_LDR) ? EXT_PC6 : EXT_PC9;
                        o_ctrl.op2_sel      = OP2_EXT;
                        o_ctrl.mem_addr_sel = MADDR_ADDER;
                        o_ctrl.alu_sel      = ALU_PASS;
                        o_ctrl.rf_w_en      = 1'b1;
                        o_ctrl.nzp_ld       = 1'b1;
                    end
                    OP_LEA: begin
                        o_ctrl.op1_sel = OP1_PC;
                        o_ctrl.ext_sel = EXT_PC9;
                        o_ctrl.op2_sel = OP2_EXT;
                        o_ctrl.alu_sel = ALU_SUM;
                        o_ctrl.rf_w_en = 1'b1;
                    end
                    OP_ST, OP_STR: begin
                        o_ctrl.op1_sel      = (i_opcode == OP_STR) ? OP1_BASE : OP1_PC;
                        o_ctrl.ext_sel      = (i_opcode == OP_STR) ? EXT_PC6 : EXT_PC9;
                        o_ctrl.op2_sel      = OP2_EXT;
                        o_ctrl.mem_addr_sel = MADDR_ADDER;
                        o_ctrl.mem_w_en     = 1'b1;
                    end
                    OP_LDI, OP_STI: begin
                        // First leg of the indirect: fetch the pointer into MDR
                        o_ctrl.op1_sel      = OP1_PC;
                        o_ctrl.ext_sel      = EXT_PC9;
                        o_ctrl.op2_sel      = OP2_EXT;
                        o_ctrl.mem_addr_sel = MADDR_ADDER;
                        o_ctrl.mdr_ld       = 1'b1;
                    end
                    OP_RTI, OP_RES, OP_TRAP: begin
                        o_ctrl = '0;
                    end
                    default: begin
                        o_ctrl = '0;
                    end
                endcase
            end
            ST_EXEC2: begin
                o_ctrl.mem_addr_sel = MADDR_MDR;
                if (i_opcode == OP_LDI) begin
                    o_ctrl.alu_sel = ALU_PASS;
                    o_ctrl.rf_w_en = 1'b1;
                    o_ctrl.nzp_ld  = 1'b1;
                end else if (i_opcode == OP_STI) begin
                    o_ctrl.mem_w_en = 1'b1;
                end
            end
            ST_HALT: begin
                o_ctrl.halted = 1'b1;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/punc_control.sv
// PUnC LC3 multicycle controller: FETCH -> DECODE -> EXEC [-> EXEC2], parks in HALT on TRAP.
// Latency: 3 cycles per instruction, 4 for LDI/STI; outputs combinational from state.
// Backpressure: none; reset low forces every output to zero immediately.
module punc_control
    import punc_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             ir_11,
    input  logic             ir_5,
    input  logic [2:0]       ir_cond,
    input  logic [2:0]       nzp,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic             pc_sel,
    output logic [1:0]       ext_sel,
    output logic [1:0]       op1_sel,
    output logic             op2_sel,
    output logic [1:0]       alu_sel,
    output logic             rf_w_en,
    output logic             rf_w_r7,
    output logic             rf_r_r7,
    output logic [1:0]       mem_addr_sel,
    output logic             mem_w_en,
    output logic             mdr_ld,
    output logic             nzp_ld,
    output logic             halted
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    ctrl_t              w_ctrl;
    ctrl_t              w_out;

    punc_ctrl_decode u_decode (
        .i_state   (r_state),
        .i_opcode  (opcode),
        .i_ir_11   (ir_11),
        .i_ir_5    (ir_5),
        .i_ir_cond (ir_cond),
        .i_nzp     (nzp),
        .o_ctrl    (w_ctrl)
    );

    // Instruction sequencing; illegal encodings fall back to FETCH
    always_comb begin
        w_next_state = ST_FETCH;
        case (r_state)
            ST_FETCH:  w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = (opcode == OP_TRAP) ? ST_HALT : ST_EXEC;
            ST_EXEC:   w_next_state = ((opcode == OP_LDI) || (opcode == OP_STI)) ? ST_EXEC2 : ST_FETCH;
            ST_EXEC2:  w_next_state = ST_FETCH;
            ST_HALT:   w_next_state = ST_HALT;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // State register; reset restarts at FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pending writes are dropped the moment reset asserts, not at the next edge
    assign w_out = rst ? w_ctrl : '0;

    assign ir_ld        = w_out.ir_ld;
    assign pc_inc       = w_out.pc_inc;
    assign pc_ld        = w_out.pc_ld;
    assign pc_sel       = w_out.pc_sel;
    assign ext_sel      = w_out.ext_sel;
    assign op1_sel      = w_out.op1_sel;
    assign op2_sel      = w_out.op2_sel;
    assign alu_sel      = w_out.alu_sel;
    assign rf_w_en      = w_out.rf_w_en;
    assign rf_w_r7      = w_out.rf_w_r7;
    assign rf_r_r7      = w_out.rf_r_r7;
    assign mem_addr_sel = w_out.mem_addr_sel;
    assign mem_w_en     = w_out.mem_w_en;
    assign mdr_ld       = w_out.mdr_ld;
    assign nzp_ld       = w_out.nzp_ld;
    assign halted       = w_out.halted;

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: directed LC3 sequences plus random instructions against a per-instruction model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Expected per-cycle control words are built from the LC3 instruction rules.
module tb_punc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       ir_11, ir_5;
    logic [2:0] ir_cond, nzp;
    logic       ir_ld, pc_inc, pc_ld, pc_sel, op2_sel;
    logic [1:0] ext_sel, op1_sel, alu_sel, mem_addr_sel;
    logic       rf_w_en, rf_w_r7, rf_r_r7, mem_w_en, mdr_ld, nzp_ld, halted;

    punc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .ir_11(ir_11), .ir_5(ir_5),
        .ir_cond(ir_cond), .nzp(nzp), .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld),
        .pc_sel(pc_sel), .ext_sel(ext_sel), .op1_sel(op1_sel), .op2_sel(op2_sel),
        .alu_sel(alu_sel), .rf_w_en(rf_w_en), .rf_w_r7(rf_w_r7), .rf_r_r7(rf_r_r7),
        .mem_addr_sel(mem_addr_sel), .mem_w_en(mem_w_en), .mdr_ld(mdr_ld),
        .nzp_ld(nzp_ld), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe bits: {ir_ld,pc_inc,pc_ld,rf_w_en,rf_w_r7,rf_r_r7,mem_w_en,mdr_ld,nzp_ld,halted}
    localparam logic [9:0] B_IR   = 10'h200;
    localparam logic [9:0] B_INC  = 10'h100;
    localparam logic [9:0] B_PCLD = 10'h080;
    localparam logic [9:0] B_RFW  = 10'h040;
    localparam logic [9:0] B_R7W  = 10'h020;
    localparam logic [9:0] B_MEMW = 10'h008;
    localparam logic [9:0] B_MDR  = 10'h004;
    localparam logic [9:0] B_NZP  = 10'h002;
    localparam logic [9:0] B_HALT = 10'h001;
    localparam int X = -1;

    wire [9:0] act_stb = {ir_ld, pc_inc, pc_ld, rf_w_en, rf_w_r7, rf_r_r7, mem_w_en, mdr_ld, nzp_ld, halted};
    wire [9:0] act_sel = {pc_sel, ext_sel, op1_sel, op2_sel, alu_sel, mem_addr_sel};

    typedef struct packed {
        logic [9:0] stb;
        logic [9:0] sel;
        logic [9:0] care;
    } exp_t;

    exp_t exp_q[$];

    // One expected cycle: strobe set plus the selects that matter (X = don't care)
    function automatic exp_t mk(logic [9:0] stb, int pcs, int ext, int op1, int op2, int alu, int mem);
        exp_t e;
        e.stb = stb; e.sel = '0; e.care = '0;
        if (pcs >= 0) begin e.sel[9]   = pcs[0];   e.care[9]   = 1'b1;  end
        if (ext >= 0) begin e.sel[8:7] = ext[1:0]; e.care[8:7] = 2'b11; end
        if (op1 >= 0) begin e.sel[6:5] = op1[1:0]; e.care[6:5] = 2'b11; end
        if (op2 >= 0) begin e.sel[4]   = op2[0];   e.care[4]   = 1'b1;  end
        if (alu >= 0) begin e.sel[3:2] = alu[1:0]; e.care[3:2] = 2'b11; end
        if (mem >= 0) begin e.sel[1:0] = mem[1:0]; e.care[1:0] = 2'b11; end
        return e;
    endfunction

    // Reference: the full cycle-by-cycle control sequence of one non-TRAP instruction
    task automatic build(input logic [15:0] ir, input logic [2:0] cc);
        int op, i5, i11;
        bit taken;
        op = int'(ir[15:12]); i5 = int'(ir[5]); i11 = int'(ir[11]);
        taken = |(ir[11:9] & cc);
        exp_q.delete();
        exp_q.push_back(mk(B_IR, X, X, X, X, X, 0));
        exp_q.push_back(mk(B_INC, X, X, X, X, X, X));
        case (op)
            1:  exp_q.push_back(mk(B_RFW | B_NZP, X, i5 ? 3 : X, 1, i5, 0, X));
            5:  exp_q.push_back(mk(B_RFW | B_NZP, X, i5 ? 3 : X, 1, i5, 1, X));
            9:  exp_q.push_back(mk(B_RFW | B_NZP, X, X, 1, X, 2, X));
            0:  exp_q.push_back(taken ? mk(B_PCLD, 0, 1, 2, 1, 0, X) : mk(10'h0, X, X, X, X, X, X));
            12: exp_q.push_back(mk(B_PCLD, 1, X, X, X, X, X));
            4:  exp_q.push_back(i11 ? mk(B_PCLD | B_RFW | B_R7W, 0, 2, 2, 1, 0, X)
                                    : mk(B_PCLD | B_RFW | B_R7W, 1, X, X, X, X, X));
            2:  exp_q.push_back(mk(B_RFW | B_NZP, X, 1, 2, 1, 3, 1));
            6:  exp_q.push_back(mk(B_RFW | B_NZP, X, 0, 0, 1, 3, 1));
            14: exp_q.push_back(mk(B_RFW, X, 1, 2, 1, 0, X));
            3:  exp_q.push_back(mk(B_MEMW, X, 1, 2, 1, X, 1));
            7:  exp_q.push_back(mk(B_MEMW, X, 0, 0, 1, X, 1));
            10: begin
                exp_q.push_back(mk(B_MDR, X, 1, 2, 1, X, 1));
                exp_q.push_back(mk(B_RFW | B_NZP, X, X, X, X, 3, 2));
            end
            11: begin
                exp_q.push_back(mk(B_MDR, X, 1, 2, 1, X, 1));
                exp_q.push_back(mk(B_MEMW, X, X, X, X, X, 2));
            end
            default: exp_q.push_back(mk(10'h0, X, X, X, X, X, X));
        endcase
    endtask

    task automatic drive(input logic [15:0] ir, input logic [2:0] cc);
        opcode = ir[15:12]; ir_11 = ir[11]; ir_5 = ir[5]; ir_cond = ir[11:9]; nzp = cc;
    endtask

    // Called mid-cycle with the DUT in FETCH; returns on the falling edge of the next FETCH cycle
    task automatic run_instr(input logic [15:0] ir, input logic [2:0] cc, input string name);
        drive(ir, cc);
        build(ir, cc);
        #1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            chk($sformatf("%s c%0d stb", name, k), act_stb, exp_q[k].stb);
            chk($sformatf("%s c%0d sel", name, k), act_sel & exp_q[k].care, exp_q[k].sel & exp_q[k].care);
            chk($sformatf("%s c%0d excl", name, k), {rf_w_en & mem_w_en, pc_inc & pc_ld}, 0);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] ir;
        rst = 1'b0;
        drive(16'h0000, 3'b000);
        #1;
        chk("reset stb", act_stb, 10'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset hold stb", act_stb, 10'h0);
        rst = 1'b1;

        run_instr(16'h127F, 3'b000, "add_imm");
        run_instr(16'h0405, 3'b010, "brz_taken");
        run_instr(16'h0405, 3'b100, "brz_not");
        run_instr(16'hA002, 3'b001, "ldi");
        run_instr(16'hB002, 3'b001, "sti");
        run_instr(16'h4803, 3'b001, "jsr");
        run_instr(16'h4080, 3'b001, "jsrr");
        run_instr(16'hC1C0, 3'b001, "ret");
        run_instr(16'hD000, 3'b001, "res_nop");
        run_instr(16'h8000, 3'b001, "rti_nop");

        for (int n = 0; n < 250; n++) begin
            ir = 16'($urandom);
            while (ir[15:12] == 4'hF) ir = 16'($urandom);
            run_instr(ir, 3'($urandom_range(0, 7)), $sformatf("rnd%0d_%04h", n, ir));
        end

        // Reset lands in the EXEC cycle of a store
        drive(16'h3005, 3'b001);
        #1;
        chk("st fetch", act_stb, B_IR);
        @(negedge clk); #1;
        chk("st decode", act_stb, B_INC);
        @(negedge clk); #1;
        chk("st exec memw", 32'(mem_w_en), 1);
        rst = 1'b0;
        #1;
        chk("st rst memw", 32'(mem_w_en), 0);
        chk("st rst stb", act_stb, 10'h0);
        @(negedge clk); #1;
        chk("rst held stb", act_stb, 10'h0);
        rst = 1'b1;
        #1;
        chk("post rst ir_ld", 32'(ir_ld), 1);
        run_instr(16'h127F, 3'b000, "post_rst_add");

        // TRAP parks the controller
        drive(16'hF025, 3'b001);
        #1;
        chk("trap fetch", act_stb, B_IR);
        @(negedge clk); #1;
        chk("trap decode", act_stb, 10'h0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            chk($sformatf("halt c%0d", c), act_stb, B_HALT);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
